// File: rtl/screen_pkg.sv
// Shared screen definitions: screen encoding and overlay window geometry,
// used by the screen controller and by the overlay renderers.
package screen_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        WIN   = 2'b10,
        LOSE  = 2'b11
    } screen_t;

    localparam int WIN_X0       = 160;
    localparam int WIN_Y0       = 60;
    localparam int WIN_W        = 320;
    localparam int WIN_H        = 240;
    localparam int HOLD_FRAMES  = 180;
    localparam int BLINK_FRAMES = 30;
    localparam int ROM_DEPTH    = WIN_W * WIN_H;
    localparam int ADDR_W       = 17;

endpackage

// File: rtl/overlay_addr_gen.sv
// Overlay window detection and incremental ROM address generation; the
// address advances once per in-window pixel instead of computing y*W+x.
module overlay_addr_gen #(
    parameter int WIN_X0 = 160,
    parameter int WIN_Y0 = 60,
    parameter int WIN_W  = 320,
    parameter int WIN_H  = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank,
    input  logic        frame_tick,
    input  logic        overlay_en,
    output logic        overlay_valid,
    output logic [16:0] rom_address
);

    localparam logic [9:0]  X_LO      = 10'(WIN_X0);
    localparam logic [9:0]  X_HI      = 10'(WIN_X0 + WIN_W - 1);
    localparam logic [9:0]  Y_LO      = 10'(WIN_Y0);
    localparam logic [9:0]  Y_HI      = 10'(WIN_Y0 + WIN_H - 1);
    localparam logic [16:0] ADDR_LAST = 17'(WIN_W * WIN_H - 1);

    logic        in_win_s;
    logic [16:0] addr_cnt_r;

    // Window membership of the pixel currently presented
    always_comb begin
        in_win_s = (draw_x >= X_LO) && (draw_x <= X_HI) &&
                   (draw_y >= Y_LO) && (draw_y <= Y_HI);
    end

    // Address counter saturates so stray coordinates can never wrap it
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_r    <= 17'd0;
            rom_address   <= 17'd0;
            overlay_valid <= 1'b0;
        end else begin
            if (frame_tick) begin
                addr_cnt_r <= 17'd0;
            end else if (in_win_s && (addr_cnt_r != ADDR_LAST)) begin
                addr_cnt_r <= addr_cnt_r + 17'd1;
            end else begin
                addr_cnt_r <= addr_cnt_r;
            end

            if (in_win_s) begin
                rom_address <= addr_cnt_r;
            end else begin
                rom_address <= rom_address;
            end

            overlay_valid <= in_win_s & blank & overlay_en;
        end
    end

endmodule

// File: rtl/screen_controller.sv
// Game-screen sequencer: title/play/win/lose state machine, frame-based
// hold and blink timers, key edge detection and overlay addressing.
module screen_controller
    import screen_pkg::*;
#(
    parameter int WIN_X0       = screen_pkg::WIN_X0,
    parameter int WIN_Y0       = screen_pkg::WIN_Y0,
    parameter int WIN_W        = screen_pkg::WIN_W,
    parameter int WIN_H        = screen_pkg::WIN_H,
    parameter int HOLD_FRAMES  = screen_pkg::HOLD_FRAMES,
    parameter int BLINK_FRAMES = screen_pkg::BLINK_FRAMES
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_key,
    input  logic        level_cleared,
    input  logic        player_dead,
    output logic [1:0]  screen_sel,
    output logic        game_enable,
    output logic        end_screen,
    output logic        overlay_valid,
    output logic [16:0] rom_address,
    output logic        blink_on
);

    localparam int                HOLD_W     = $clog2(HOLD_FRAMES + 1);
    localparam int                BLINK_W    = $clog2(BLINK_FRAMES);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    screen_t            state_r;
    screen_t            state_next_s;
    logic               key_prev_r;
    logic               key_rise_s;
    logic               frame_tick_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [1:0]         screen_sel_s;
    logic               game_enable_s;
    logic               end_screen_s;
    logic               overlay_en_s;

    // Key edge detection
    always_comb begin
        key_rise_s = start_key & ~key_prev_r;
    end

    // Frame tick lands one cycle after the (0,0) pixel; key history every cycle
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
            key_prev_r   <= 1'b0;
        end else begin
            frame_tick_r <= (DrawX == 10'd0) && (DrawY == 10'd0);
            key_prev_r   <= start_key;
        end
    end

    // State register
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_r <= TITLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a simultaneous death beats the level clear
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TITLE: begin
                if (key_rise_s) state_next_s = PLAY;
                else            state_next_s = TITLE;
            end
            PLAY: begin
                if (player_dead)        state_next_s = LOSE;
                else if (level_cleared) state_next_s = WIN;
                else                    state_next_s = PLAY;
            end
            WIN, LOSE: begin
                if (key_rise_s && (hold_cnt_r == HOLD_MAX)) state_next_s = TITLE;
                else                                        state_next_s = state_r;
            end
            default: state_next_s = TITLE;
        endcase
    end

    // Output decode of the current state
    always_comb begin
        screen_sel_s  = 2'(state_r);
        game_enable_s = (state_r == PLAY);
        end_screen_s  = (state_r == WIN) || (state_r == LOSE);
        overlay_en_s  = (state_r != PLAY);
    end

    // Registered screen outputs
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            screen_sel  <= 2'b00;
            game_enable <= 1'b0;
            end_screen  <= 1'b0;
        end else begin
            screen_sel  <= screen_sel_s;
            game_enable <= game_enable_s;
            end_screen  <= end_screen_s;
        end
    end

    // End-screen hold timer: zero outside WIN/LOSE, saturating inside
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else if ((state_r == WIN) || (state_r == LOSE)) begin
            if (frame_tick_r && (hold_cnt_r != HOLD_MAX)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end else begin
            hold_cnt_r <= '0;
        end
    end

    // Prompt blink, parked at its reset phase during play
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blink_cnt_r <= '0;
            blink_on    <= 1'b1;
        end else if (state_r == PLAY) begin
            blink_cnt_r <= '0;
            blink_on    <= 1'b1;
        end else if (frame_tick_r) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
                blink_on    <= ~blink_on;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
                blink_on    <= blink_on;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
            blink_on    <= blink_on;
        end
    end

    overlay_addr_gen #(
        .WIN_X0 (WIN_X0),
        .WIN_Y0 (WIN_Y0),
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H)
    ) u_addr_gen (
        .clk           (vga_clk),
        .reset         (reset),
        .draw_x        (DrawX),
        .draw_y        (DrawY),
        .blank         (blank),
        .frame_tick    (frame_tick_r),
        .overlay_en    (overlay_en_s),
        .overlay_valid (overlay_valid),
        .rom_address   (rom_address)
    );

endmodule

// File: doc/screen_controller.md
Name: screen_controller

Overview:
Game-screen sequencer that decides which full-screen overlay (title, win, lose) is shown and when the playfield is live.
- Owns the state machine, frame-based hold timers and key-press edge detection.
- Generates the shared overlay ROM address incrementally, replacing per-pixel multiplies.
- Sits between the game logic and the overlay renderers. Its outputs drive the overlay ROM/palette path and the color mux.

Parameters:
WIN_X0, 160, left column of the 320x240 overlay window
WIN_Y0, 60, top row of the overlay window
WIN_W, 320, overlay width in pixels
WIN_H, 240, overlay height in lines
HOLD_FRAMES, 180, frames a win/lose screen is held before a key press is accepted
BLINK_FRAMES, 30, half-period of the "press key" blink, in frames

Ports:
vga_clk  in  1  pixel clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column from the VGA controller
DrawY  in  10  current pixel row
blank  in  1  high during active video
start_key  in  1  raw start/continue key level, already synchronized
level_cleared  in  1  one-cycle pulse from game logic
player_dead  in  1  one-cycle pulse from game logic
screen_sel  out  2  0=TITLE, 1=PLAY, 2=WIN, 3=LOSE
game_enable  out  1  high only in PLAY
end_screen  out  1  high in WIN or LOSE
overlay_valid  out  1  registered: current pixel is inside the window and blank=1
rom_address  out  17  registered overlay ROM address, 0..76799
blink_on  out  1  blink phase for the prompt text

Behaviour:
- Reset values: state TITLE, screen_sel=0, game_enable=0, end_screen=0, overlay_valid=0, rom_address=0, blink_on=1, hold counter=0, blink counter=0, key_prev=0.
- frame_tick: one-cycle pulse when DrawX==0 and DrawY==0. It is registered, so it asserts in the cycle after that pixel.
- key_rise: start_key & ~key_prev. key_prev updates every cycle.
- FSM transitions:
  - TITLE -> PLAY on key_rise.
  - PLAY -> WIN on level_cleared; PLAY -> LOSE on player_dead. If both pulse in the same cycle, LOSE wins.
  - WIN/LOSE: the hold counter clears on entry and increments on each frame_tick, saturating at HOLD_FRAMES.
  - WIN -> TITLE, and LOSE -> TITLE, on key_rise only once the counter equals HOLD_FRAMES. Earlier presses are ignored and are not queued.
  - level_cleared and player_dead are ignored outside PLAY.
- screen_sel, game_enable and end_screen are registered decodes of the state. They change the cycle after the transition.
- Blink: the counter counts frame_ticks 0..BLINK_FRAMES-1. blink_on toggles on wrap. Both are held at reset values (counter 0, blink_on=1) while in PLAY.
- Address generator:
  - in_win = DrawX in [WIN_X0, WIN_X0+WIN_W-1] and DrawY in [WIN_Y0, WIN_Y0+WIN_H-1].
  - A counter clears to 0 on frame_tick.
  - On each cycle with in_win=1, rom_address <= counter and the counter increments. Latency is 1 cycle: rom_address for pixel (X,Y) is valid the cycle after DrawX/DrawY show it.
  - The counter saturates at 76799. It never wraps within a frame, even if DrawX/DrawY misbehave.
  - Outside the window, rom_address holds its last value and overlay_valid=0.
- overlay_valid <= in_win & blank & (state!=PLAY). It is forced to 0 in PLAY.
- Reset asserted mid-frame or mid-hold: every register returns to its reset value on the next edge. The address counter restarts at the next frame_tick.

Decomposition:
- Shared package screen_pkg:
  - enum screen_t {TITLE, PLAY, WIN, LOSE} encoded 2'b00..2'b11.
  - Overlay geometry constants and ROM_DEPTH=76800, reused by the overlay renderers.
- One sub-module, overlay_addr_gen: window detect, incremental address counter, overlay_valid register. It is instantiated once; the FSM, timers and blink logic stay in the top level.

Test Plan:
- Reset, then one key_rise -> screen_sel goes 0->1 and game_enable=1 one cycle after the state changes; blink counter frozen.
- In PLAY, pulse level_cleared and player_dead in the same cycle -> screen_sel=3, end_screen=1.
- In WIN, press the key at frame 10 -> stays WIN. Press again after 180 frame_ticks -> screen_sel=0. A held key with no new rising edge -> no transition.
- Full 800x525 frame in TITLE:
  - (160,60) -> rom_address=0 next cycle; (479,60) -> 319; (160,61) -> 320; (479,299) -> 76799.
  - overlay_valid high for exactly 76800 cycles.
- With blank forced low, or in PLAY -> overlay_valid=0 for the entire frame; address counter still cycles.
- Assert reset for one cycle in LOSE at hold count 100 -> all outputs at reset values next cycle; counter restarts at the next frame_tick.
